raggedstone_spinn_aer_if_pkt_arbiter: RTL

//  Shares the single SpiNNaker link sender packet input between two 72-bit packet sources,
//  e.g. the AER-to-SpiNNaker mapper (port 0) and a status/monitor packet generator (port 1).

---
 rtl/raggedstone_spinn_aer_if_pkt_arbiter_if.sv | 25 ++
 rtl/raggedstone_spinn_aer_if_pkt_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/raggedstone_spinn_aer_if_pkt_arbiter_if.sv
// Packet bus between the two packet sources, the arbiter and the SpiNNaker link sender.
// The slave modport is the arbiter's view; master is the view of the producers/sender side.
interface raggedstone_spinn_aer_if_pkt_arbiter_if #(
    parameter int PKT_BITS = 72
);
    logic [PKT_BITS-1:0] p0_data;
    logic                p0_vld;
    logic                p0_rdy;
    logic [PKT_BITS-1:0] p1_data;
    logic                p1_vld;
    logic                p1_rdy;
    logic [PKT_BITS-1:0] out_data;
    logic                out_vld;
    logic                out_rdy;

    modport master (
        output p0_data, p0_vld, p1_data, p1_vld, out_rdy,
        input  p0_rdy, p1_rdy, out_data, out_vld
    );

    modport slave (
        input  p0_data, p0_vld, p1_data, p1_vld, out_rdy,
        output p0_rdy, p1_rdy, out_data, out_vld
    );
endinterface

// File: rtl/raggedstone_spinn_aer_if_pkt_arbiter.sv
// Two-port weighted round-robin packet arbiter with a one-entry registered output stage.
// Optional saturating per-port accept counters: define RAGGEDSTONE_ARB_STATS_EN.
module raggedstone_spinn_aer_if_pkt_arbiter #(
    parameter int PKT_BITS = 72,
    parameter int BURST    = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    raggedstone_spinn_aer_if_pkt_arbiter_if.slave bus,
    output logic                  o_owner,
    output logic [CNT_BITS-1:0]   o_cnt0,
    output logic [CNT_BITS-1:0]   o_cnt1
);
    localparam int            BW      = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_V = BW'(BURST);

    typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} own_t;

    own_t                r_state;
    logic [BW-1:0]       r_burst;
    logic [PKT_BITS-1:0] r_out_data;
    logic                r_out_vld;

    logic                w_space;
    logic                w_sel;
    logic                w_grant;
    logic                w_rdy0;
    logic                w_rdy1;
    logic                w_acc0;
    logic                w_acc1;
    logic                w_acc;
    logic [BW-1:0]       w_run;
    logic [PKT_BITS-1:0] w_acc_data;

    // Port selection, ready generation and the next run length of the selected port.
    always_comb begin
        w_space = !r_out_vld || bus.out_rdy;
        if (bus.p0_vld && bus.p1_vld) begin
            w_sel = (r_state == OWN1);
        end else if (bus.p1_vld) begin
            w_sel = 1'b1;
        end else begin
            w_sel = 1'b0;
        end
        w_grant    = i_en && w_space && (bus.p0_vld || bus.p1_vld) && !i_rst;
        w_rdy0     = w_grant && !w_sel;
        w_rdy1     = w_grant && w_sel;
        w_acc0     = w_rdy0 && bus.p0_vld;
        w_acc1     = w_rdy1 && bus.p1_vld;
        w_acc      = w_acc0 || w_acc1;
        w_acc_data = w_sel ? bus.p1_data : bus.p0_data;
        if ((r_state == OWN1) == w_sel) begin
            w_run = r_burst + BW'(1);
        end else begin
            w_run = BW'(1);
        end
    end

    assign bus.p0_rdy   = w_rdy0;
    assign bus.p1_rdy   = w_rdy1;
    assign bus.out_data = r_out_data;
    assign bus.out_vld  = r_out_vld;
    assign o_owner      = r_state;

    // Quantum FSM: the owner keeps priority until it has used BURST consecutive accepts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= OWN0;
            r_burst <= '0;
        end else if (w_acc) begin
            if (w_run == BURST_V) begin
                r_state <= w_sel ? OWN0 : OWN1;
                r_burst <= '0;
            end else begin
                r_state <= w_sel ? OWN1 : OWN0;
                r_burst <= w_run;
            end
        end else begin
            r_state <= r_state;
            r_burst <= r_burst;
        end
    end

    // Output holding register; data is only replaced on a new accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else if (w_acc) begin
            r_out_vld  <= 1'b1;
            r_out_data <= w_acc_data;
        end else if (bus.out_rdy) begin
            r_out_vld  <= 1'b0;
        end else begin
            r_out_vld  <= r_out_vld;
        end
    end

`ifdef RAGGEDSTONE_ARB_STATS_EN
    logic [CNT_BITS-1:0] r_cnt0;
    logic [CNT_BITS-1:0] r_cnt1;

    // Saturating accept counters, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_acc0 && (r_cnt0 != {CNT_BITS{1'b1}})) begin
                r_cnt0 <= r_cnt0 + CNT_BITS'(1);
            end else begin
                r_cnt0 <= r_cnt0;
            end
            if (w_acc1 && (r_cnt1 != {CNT_BITS{1'b1}})) begin
                r_cnt1 <= r_cnt1 + CNT_BITS'(1);
            end else begin
                r_cnt1 <= r_cnt1;
            end
        end
    end

    assign o_cnt0 = r_cnt0;
    assign o_cnt1 = r_cnt1;
`else
    assign o_cnt0 = '0;
    assign o_cnt1 = '0;
`endif
endmodule
